// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared FIFO types and defaults.
// Read-mode enum plus threshold constants.
package sync_fifo_ctrl_pkg;

   typedef enum logic {
      FIFO_REGISTERED = 1'b0,
      FIFO_SHOW_AHEAD = 1'b1
   } fifo_mode_e;

   localparam int AE_THRESH_DEF = 1;
   // almost_full default sits this far below DEPTH
   localparam int AF_MARGIN_DEF = 1;

   function automatic fifo_mode_e fifo_mode(input int fwft);
      return (fwft != 0) ? FIFO_SHOW_AHEAD : FIFO_REGISTERED;
   endfunction

endpackage

// File: rtl/fifo_storage.sv
// FIFO entry array.
// Rising-edge write port, combinational read port.
module fifo_storage #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, flags, sticky errors.
// Registered or show-ahead read path selected by FWFT.
module sync_fifo_ctrl
   import sync_fifo_ctrl_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int LOG2_OF_DEPTH = 4,
   parameter int FWFT          = 0,
   parameter int AF_THRESH     = (2**LOG2_OF_DEPTH) - AF_MARGIN_DEF,
   parameter int AE_THRESH     = AE_THRESH_DEF
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   input  logic                   we,
   output logic                   full,
   output logic                   almost_full,
   output logic [WIDTH-1:0]       qout,
   input  logic                   re,
   output logic                   empty,
   output logic                   almost_empty,
   output logic                   last,
   output logic [LOG2_OF_DEPTH:0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int L = LOG2_OF_DEPTH;
   localparam fifo_mode_e MODE = fifo_mode(FWFT);
   localparam logic [L:0] DEPTH_C = {1'b1, {L{1'b0}}};
   localparam logic [L:0] ONE     = {{L{1'b0}}, 1'b1};
   localparam logic [L:0] AF_C    = AF_THRESH[L:0];
   localparam logic [L:0] AE_C    = AE_THRESH[L:0];

   logic [L:0]       wr_ptr;
   logic [L:0]       rd_ptr;
   logic [L:0]       cnt;
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] qout_q;
   logic             ovf_q;
   logic             unf_q;
   logic             push_ok;
   logic             pop_ok;

   assign cnt          = wr_ptr - rd_ptr;
   assign full         = (cnt == DEPTH_C);
   assign empty        = (wr_ptr == rd_ptr);
   assign almost_full  = (cnt >= AF_C);
   assign almost_empty = (cnt <= AE_C);
   assign last         = (cnt == ONE);
   assign count        = cnt;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   assign push_ok = we & ~full & ~flush;
   assign pop_ok  = re & ~empty & ~flush;

   fifo_storage #(
      .WIDTH (WIDTH),
      .AW    (L)
   ) u_storage (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr[L-1:0]),
      .wdata (din),
      .raddr (rd_ptr[L-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         qout_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok)    wr_ptr <= wr_ptr + ONE;
         if (pop_ok)     rd_ptr <= rd_ptr + ONE;
         if (pop_ok)     qout_q <= rdata;
         if (we && full) ovf_q  <= 1'b1;
         if (re && empty) unf_q <= 1'b1;
      end
   end

   assign qout = (MODE == FIFO_SHOW_AHEAD) ? rdata : qout_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench: registered and show-ahead FIFOs driven in lockstep
// against a queue-based reference.
module tb_sync_fifo_ctrl;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       flush;
   logic [7:0] din;
   logic       we;
   logic       re;

   logic       full0, af0, empty0, ae0, last0, ov0, un0;
   logic       full1, af1, empty1, ae1, last1, ov1, un1;
   logic [7:0] q0, q1;
   logic [2:0] cnt0, cnt1;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mq[$];
   logic [7:0] m_qreg;
   logic       m_ov;
   logic       m_un;

   always #5 clk = ~clk;

   sync_fifo_ctrl #(.WIDTH(8), .LOG2_OF_DEPTH(2), .FWFT(0)) u_reg (
      .clk(clk), .arst_n(arst_n), .flush(flush), .din(din), .we(we),
      .full(full0), .almost_full(af0), .qout(q0), .re(re),
      .empty(empty0), .almost_empty(ae0), .last(last0), .count(cnt0),
      .overflow(ov0), .underflow(un0)
   );

   sync_fifo_ctrl #(.WIDTH(8), .LOG2_OF_DEPTH(2), .FWFT(1)) u_sa (
      .clk(clk), .arst_n(arst_n), .flush(flush), .din(din), .we(we),
      .full(full1), .almost_full(af1), .qout(q1), .re(re),
      .empty(empty1), .almost_empty(ae1), .last(last1), .count(cnt1),
      .overflow(ov1), .underflow(un1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      check("count", 32'(cnt0), 32'(n));
      check("full", 32'(full0), 32'(n == 4));
      check("empty", 32'(empty0), 32'(n == 0));
      check("almost_full", 32'(af0), 32'(n >= 3));
      check("almost_empty", 32'(ae0), 32'(n <= 1));
      check("last", 32'(last0), 32'(n == 1));
      check("overflow", 32'(ov0), 32'(m_ov));
      check("underflow", 32'(un0), 32'(m_un));
      check("qout_reg", 32'(q0), 32'(m_qreg));
      check("sa_count", 32'(cnt1), 32'(n));
      check("sa_flags", {28'd0, full1, empty1, af1, ae1},
            {28'd0, n == 4, n == 0, n >= 3, n <= 1});
      check("sa_sticky", {29'd0, last1, ov1, un1}, {29'd0, n == 1, m_ov, m_un});
      if (n > 0) check("qout_sa", 32'(q1), 32'(mq[0]));
   endtask

   task automatic step(input logic r, input logic f, input logic w,
                       input logic rd, input logic [7:0] d);
      bit was_full, was_empty;
      arst_n = r; flush = f; we = w; re = rd; din = d;
      if (!r) begin
         mq.delete(); m_qreg = '0; m_ov = 1'b0; m_un = 1'b0;
      end else if (f) begin
         mq.delete();
      end else begin
         was_full  = (mq.size() == 4);
         was_empty = (mq.size() == 0);
         if (w && was_full) m_ov = 1'b1;
         if (rd && was_empty) m_un = 1'b1;
         if (rd && !was_empty) m_qreg = mq.pop_front();
         if (w && !was_full) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      arst_n = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; din = '0;
      m_qreg = '0; m_ov = 1'b0; m_un = 1'b0;
      #2;
      step(0, 0, 0, 0, 8'h00);
      check("reset_qout", 32'(q0), 32'h0);

      step(1, 0, 1, 0, 8'h11);
      step(1, 0, 1, 0, 8'h22);
      step(1, 0, 1, 0, 8'h33);
      step(1, 0, 1, 0, 8'h44);
      step(1, 0, 1, 0, 8'h55);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 8'h00);
      check("hold_44", 32'(q0), 32'h44);

      step(0, 0, 0, 0, 8'h00);
      step(1, 0, 1, 0, 8'hA5);
      check("fwft_a5", 32'(q1), 32'hA5);
      step(1, 0, 0, 1, 8'h00);

      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 8'(r * 3 + k));
         for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 8'h00);
      end

      step(0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 8'hC0 + 8'(k));
      step(1, 0, 1, 1, 8'hEE);
      for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 8'h00);
      step(1, 0, 1, 1, 8'h77);

      step(1, 0, 1, 0, 8'h01);
      step(1, 0, 1, 0, 8'h02);
      step(1, 1, 1, 0, 8'h03);
      step(1, 0, 1, 0, 8'h09);
      step(0, 0, 1, 0, 8'h0A);

      for (int i = 0; i < 3000; i++) begin
         logic r, f, w, rd;
         r  = ($urandom_range(0, 199) != 0);
         f  = ($urandom_range(0, 31) == 0);
         w  = ($urandom_range(0, 99) < 55);
         rd = ($urandom_range(0, 99) < 50);
         step(r, f, w, rd, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
